// File: rtl/lcd_rx_monitor.sv
// rtl/lcd_rx_monitor.sv - HD44780-style LCD bus receiver with DDRAM mirror and busy model
module lcd_rx_monitor #(
    parameter int SYNC_STAGES  = 2,
    parameter int LONG_CYCLES  = 82000,
    parameter int SHORT_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_db,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       char_valid,
    output logic [6:0] char_addr,
    output logic [7:0] char_data,
    output logic [6:0] addr_cnt,
    output logic       mode_4bit,
    output logic       display_on,
    output logic       busy,
    output logic [2:0] err
);
    localparam int CW = $clog2(LONG_CYCLES + SHORT_CYCLES + 1);
    localparam logic [CW-1:0] LONG_M1  = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] SHORT_M1 = CW'(SHORT_CYCLES - 1);

    typedef enum logic [1:0] {MODE8, HI, LO} nib_state_t;

    nib_state_t    state;
    logic [3:0]    hi_nib;
    logic          inc_mode;
    logic [CW-1:0] busy_cnt;
    logic          fill_active;
    logic [6:0]    fill_idx;
    logic [7:0]    mem [80];

    // bus bits packed as {e, rs, rw, db[7:4]}
    logic [6:0] sync_q [SYNC_STAGES];
    logic [6:0] bus_d;
    logic       e_sync, e_d, rs_d, rw_d;
    logic [3:0] nib_d;
    logic       unused_db;

    assign unused_db = ^lcd_db[3:0];
    assign e_sync    = sync_q[SYNC_STAGES-1][6];
    assign e_d       = bus_d[6];
    assign rs_d      = bus_d[5];
    assign rw_d      = bus_d[4];
    assign nib_d     = bus_d[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            bus_d <= '0;
        end else begin
            sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_db[7:4]};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            bus_d <= sync_q[SYNC_STAGES-1];
        end
    end

    function automatic logic legal(input logic [6:0] a);
        return a[5:0] < 6'd40;
    endfunction

    function automatic logic [6:0] ram_idx(input logic [6:0] a);
        return a[6] ? 7'd40 + {1'b0, a[5:0]} : {1'b0, a[5:0]};
    endfunction

    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else     return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    endfunction

    logic       strobe, exec, is_fset, is_long, wr_en;
    logic [7:0] exec_byte, wr_data;
    logic [6:0] wr_idx;

    always_comb begin
        strobe    = e_d & ~e_sync;
        exec_byte = (state == LO) ? {hi_nib, nib_d} : {nib_d, 4'h0};
        exec      = strobe & ~rw_d & ~busy & (state != HI);
        is_fset   = ~rs_d & (exec_byte[7:5] == 3'b001);
        is_long   = ~rs_d & (exec_byte[7:2] == 6'd0) & (exec_byte[1:0] != 2'd0);
        wr_en     = ~reset & (fill_active | (exec & rs_d));
        wr_idx    = fill_active ? fill_idx : ram_idx(addr_cnt);
        wr_data   = fill_active ? 8'h20 : exec_byte;
    end

    // DDRAM deliberately has no reset so a reset mid-clear keeps partial contents
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= MODE8;
            hi_nib      <= '0;
            mode_4bit   <= 1'b0;
            addr_cnt    <= '0;
            inc_mode    <= 1'b1;
            display_on  <= 1'b0;
            busy        <= 1'b0;
            busy_cnt    <= '0;
            fill_active <= 1'b0;
            fill_idx    <= '0;
            err         <= '0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= '0;
            char_valid  <= 1'b0;
            char_addr   <= '0;
            char_data   <= '0;
            rd_data     <= '0;
        end else begin
            cmd_valid  <= 1'b0;
            char_valid <= 1'b0;
            rd_data    <= legal(rd_addr) ? mem[ram_idx(rd_addr)] : 8'h00;

            if (busy) begin
                if (busy_cnt == '0) busy <= 1'b0;
                else busy_cnt <= busy_cnt - CW'(1);
            end
            if (fill_active) begin
                if (fill_idx == 7'd79) fill_active <= 1'b0;
                else fill_idx <= fill_idx + 7'd1;
            end

            if (strobe) begin
                if (rw_d) err[1] <= 1'b1;
                else if (busy) err[0] <= 1'b1;
                else begin
                    case (state)
                        MODE8: if (is_fset && !exec_byte[4]) begin
                            state     <= HI;
                            mode_4bit <= 1'b1;
                        end
                        HI: begin
                            hi_nib <= nib_d;
                            state  <= LO;
                        end
                        default: begin
                            state <= HI;
                            if (is_fset && exec_byte[4]) begin
                                state     <= MODE8;
                                mode_4bit <= 1'b0;
                            end
                        end
                    endcase
                end
            end

            if (exec) begin
                busy     <= 1'b1;
                busy_cnt <= is_long ? LONG_M1 : SHORT_M1;
                if (rs_d) begin
                    char_valid <= 1'b1;
                    char_addr  <= addr_cnt;
                    char_data  <= exec_byte;
                    addr_cnt   <= step_addr(addr_cnt, inc_mode);
                end else begin
                    cmd_valid <= 1'b1;
                    cmd_byte  <= exec_byte;
                    if (exec_byte == 8'h01) begin
                        addr_cnt    <= '0;
                        inc_mode    <= 1'b1;
                        fill_active <= 1'b1;
                        fill_idx    <= '0;
                    end else if (exec_byte[7:1] == 7'b0000001) begin
                        addr_cnt <= '0;
                    end else if (exec_byte[7:2] == 6'b000001) begin
                        inc_mode <= exec_byte[1];
                    end else if (exec_byte[7:3] == 5'b00001) begin
                        display_on <= exec_byte[2];
                    end else if (exec_byte[7]) begin
                        if (legal(exec_byte[6:0])) begin
                            addr_cnt <= exec_byte[6:0];
                        end else begin
                            addr_cnt <= {exec_byte[6], 6'b0};
                            err[2]   <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_rx_monitor.sv
// tb/tb_lcd_rx_monitor.sv - directed table-driven bench for lcd_rx_monitor
module tb_lcd_rx_monitor;
    localparam int LONG  = 300;
    localparam int SHORT = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_db;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       char_valid;
    logic [6:0] char_addr;
    logic [7:0] char_data;
    logic [6:0] addr_cnt;
    logic       mode_4bit, display_on, busy;
    logic [2:0] err;

    lcd_rx_monitor #(.SYNC_STAGES(2), .LONG_CYCLES(LONG), .SHORT_CYCLES(SHORT)) dut (
        .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_db(lcd_db), .rd_addr(rd_addr), .rd_data(rd_data), .cmd_valid(cmd_valid),
        .cmd_byte(cmd_byte), .char_valid(char_valid), .char_addr(char_addr),
        .char_data(char_data), .addr_cnt(addr_cnt), .mode_4bit(mode_4bit),
        .display_on(display_on), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int cmd_cnt = 0, char_cnt = 0, cmd_cyc = 0;
    logic [7:0] last_cmd = '0, last_cd = '0;
    logic [6:0] last_ca = '0;
    logic       cmd_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid) begin
            cmd_cnt  <= cmd_cnt + 1;
            last_cmd <= cmd_byte;
            cmd_busy <= busy;
            cmd_cyc  <= cyc;
        end
        if (char_valid) begin
            char_cnt <= char_cnt + 1;
            last_ca  <= char_addr;
            last_cd  <= char_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic nib(input logic rs, input logic rw, input logic [3:0] n);
        @(posedge clk); #1;
        lcd_rs = rs;
        lcd_rw = rw;
        lcd_db = {n, 4'($urandom_range(15))};
        lcd_e  = 1'b1;
        repeat (2) @(posedge clk);
        #1 lcd_e = 1'b0;
        fall_cyc = cyc;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (6) @(posedge clk);
        while (busy && n < LONG + 100) begin
            @(posedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
        end
        #1;
    endtask

    task automatic measure_busy(output int len);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 20);
        len = 0;
        while (busy && len < LONG + 100) begin
            len++;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, output int blen);
        nib(rs, 1'b0, b[7:4]);
        wait_idle();
        nib(rs, 1'b0, b[3:0]);
        measure_busy(blen);
    endtask

    task automatic rb(input logic [6:0] a, input logic [7:0] exp);
        rd_addr = a;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk($sformatf("rd_data@%02h", a), rd_data, exp);
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] b;
        logic [6:0] ac;
        logic [6:0] ca;
    } vec_t;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } rb_t;

    vec_t vt[16];
    rb_t  rt[8];
    rb_t  rr[6];

    initial begin
        logic [3:0] pwr[4];
        logic [7:0] cfg[4];
        int bl, c0, h0, exp_bl, n;

        vt[0]  = '{1'b0, 8'h80, 7'h00, 7'h00};
        vt[1]  = '{1'b1, 8'h48, 7'h01, 7'h00};
        vt[2]  = '{1'b1, 8'h69, 7'h02, 7'h01};
        vt[3]  = '{1'b0, 8'hA7, 7'h27, 7'h00};
        vt[4]  = '{1'b1, 8'h41, 7'h40, 7'h27};
        vt[5]  = '{1'b0, 8'h04, 7'h40, 7'h00};
        vt[6]  = '{1'b1, 8'h42, 7'h27, 7'h40};
        vt[7]  = '{1'b1, 8'h43, 7'h26, 7'h27};
        vt[8]  = '{1'b0, 8'h06, 7'h26, 7'h00};
        vt[9]  = '{1'b0, 8'hE7, 7'h67, 7'h00};
        vt[10] = '{1'b1, 8'h44, 7'h00, 7'h67};
        vt[11] = '{1'b0, 8'h04, 7'h00, 7'h00};
        vt[12] = '{1'b1, 8'h45, 7'h67, 7'h00};
        vt[13] = '{1'b0, 8'h06, 7'h67, 7'h00};
        vt[14] = '{1'b0, 8'h02, 7'h00, 7'h00};
        vt[15] = '{1'b0, 8'hC5, 7'h45, 7'h00};

        rt[0] = '{7'h01, 8'h69};
        rt[1] = '{7'h00, 8'h45};
        rt[2] = '{7'h27, 8'h43};
        rt[3] = '{7'h40, 8'h42};
        rt[4] = '{7'h67, 8'h44};
        rt[5] = '{7'h26, 8'h20};
        rt[6] = '{7'h30, 8'h00};
        rt[7] = '{7'h05, 8'h20};

        // after a clear aborted 30 cycles in: indices 0..29 filled, the rest kept
        rr[0] = '{7'h00, 8'h20};
        rr[1] = '{7'h1C, 8'h20};
        rr[2] = '{7'h1D, 8'h20};
        rr[3] = '{7'h1E, 8'hA3};
        rr[4] = '{7'h40, 8'h42};
        rr[5] = '{7'h67, 8'h44};

        pwr[0] = 4'h3; pwr[1] = 4'h3; pwr[2] = 4'h3; pwr[3] = 4'h2;
        cfg[0] = 8'h28; cfg[1] = 8'h06; cfg[2] = 8'h0C; cfg[3] = 8'h01;

        reset = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_db = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_addr_cnt", addr_cnt, 0);
        chk("reset_mode_4bit", mode_4bit, 0);
        chk("reset_display_on", display_on, 0);
        chk("reset_err", err, 0);
        chk("reset_cmd_byte", cmd_byte, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_pulses", {cmd_valid, char_valid}, 0);

        for (int i = 0; i < 4; i++) begin
            c0 = cmd_cnt;
            nib(1'b0, 1'b0, pwr[i]);
            if (i == 1) begin
                measure_busy(bl);
                chk("pwr_short_busy_len", bl, SHORT);
            end else begin
                wait_idle();
            end
            if (i == 0) begin
                chk("strobe_to_cmd_latency", cmd_cyc - fall_cyc, 3);
                chk("busy_with_cmd_valid", cmd_busy, 1);
            end
            chk($sformatf("pwr%0d_cmd_count", i), cmd_cnt - c0, 1);
            chk($sformatf("pwr%0d_cmd_byte", i), last_cmd, {pwr[i], 4'h0});
            chk($sformatf("pwr%0d_mode_4bit", i), mode_4bit, (i == 3) ? 1 : 0);
        end

        for (int i = 0; i < 4; i++) begin
            send_byte(1'b0, cfg[i], bl);
            chk($sformatf("cfg%0d_cmd_byte", i), last_cmd, cfg[i]);
            if (i == 3) chk("clear_busy_len", bl, LONG);
        end
        chk("cfg_display_on", display_on, 1);
        chk("cfg_mode_4bit", mode_4bit, 1);
        chk("cfg_addr_cnt", addr_cnt, 0);
        rb(7'h05, 8'h20);

        for (int i = 0; i < 16; i++) begin
            c0 = cmd_cnt;
            h0 = char_cnt;
            send_byte(vt[i].rs, vt[i].b, bl);
            exp_bl = (!vt[i].rs && vt[i].b >= 8'h01 && vt[i].b <= 8'h03) ? LONG : SHORT;
            if (vt[i].rs) begin
                chk($sformatf("vec%0d_char_count", i), char_cnt - h0, 1);
                chk($sformatf("vec%0d_char_addr", i), last_ca, vt[i].ca);
                chk($sformatf("vec%0d_char_data", i), last_cd, vt[i].b);
            end else begin
                chk($sformatf("vec%0d_cmd_count", i), cmd_cnt - c0, 1);
                chk($sformatf("vec%0d_cmd_byte", i), last_cmd, vt[i].b);
            end
            chk($sformatf("vec%0d_addr_cnt", i), addr_cnt, vt[i].ac);
            chk($sformatf("vec%0d_busy_len", i), bl, exp_bl);
        end
        for (int i = 0; i < 8; i++) rb(rt[i].a, rt[i].d);
        chk("no_err_yet", err, 0);

        // strobe landing inside the busy window of a data write
        h0 = char_cnt;
        c0 = cmd_cnt;
        nib(1'b1, 1'b0, 4'h5);
        wait_idle();
        nib(1'b1, 1'b0, 4'h0);
        repeat (10) @(posedge clk);
        nib(1'b0, 1'b0, 4'h8);
        wait_idle();
        chk("err_busy_edge", err, 3'b001);
        chk("busy_edge_char_count", char_cnt - h0, 1);
        chk("busy_edge_no_cmd", cmd_cnt - c0, 0);
        rb(7'h45, 8'h50);
        send_byte(1'b0, 8'h80, bl);
        chk("after_busy_edge_cmd", last_cmd, 8'h80);
        chk("after_busy_edge_ac", addr_cnt, 0);

        c0 = cmd_cnt;
        nib(1'b0, 1'b1, 4'h8);
        wait_idle();
        chk("err_rw_edge", err, 3'b011);
        chk("rw_edge_no_cmd", cmd_cnt - c0, 0);
        send_byte(1'b0, 8'h81, bl);
        chk("after_rw_cmd", last_cmd, 8'h81);
        chk("after_rw_ac", addr_cnt, 7'h01);

        send_byte(1'b0, 8'hB0, bl);
        chk("err_illegal_addr", err, 3'b111);
        chk("illegal_addr_ac", addr_cnt, 7'h00);

        send_byte(1'b0, 8'h30, bl);
        chk("fset_dl1_mode_4bit", mode_4bit, 0);
        nib(1'b0, 1'b0, 4'h2);
        wait_idle();
        chk("mode8_fset_cmd", last_cmd, 8'h20);
        chk("mode8_fset_mode_4bit", mode_4bit, 1);

        send_byte(1'b0, 8'h9C, bl);
        send_byte(1'b1, 8'hA1, bl);
        send_byte(1'b1, 8'hA2, bl);
        send_byte(1'b1, 8'hA3, bl);
        chk("prefill_ac", addr_cnt, 7'h1F);

        c0 = cmd_cnt;
        nib(1'b0, 1'b0, 4'h0);
        wait_idle();
        nib(1'b0, 1'b0, 4'h1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_valid && n < 20);
        chk("clear_cmd_seen", cmd_valid, 1);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midclear_busy", busy, 0);
        chk("midclear_addr_cnt", addr_cnt, 0);
        chk("midclear_mode_4bit", mode_4bit, 0);
        chk("midclear_err", err, 0);
        repeat (SHORT) @(negedge clk);
        chk("midclear_busy_stays_low", busy, 0);
        for (int i = 0; i < 6; i++) rb(rr[i].a, rr[i].d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_rx_monitor.md
Name: lcd_rx_monitor

Overview:
- Receiving end of the HD44780-style character-LCD bus that the LCD controller drives: lcd_e, lcd_rs, lcd_rw, lcd_db.
- Samples the bus and reassembles bytes, including the 8-bit power-up nibbles and 4-bit mode pairs.
- Decodes instructions, maintains an 80-byte DDRAM image and address counter, and models busy time.
- Used as an on-chip display mirror, for example for UART or VGA readback, and as a synthesizable responder for controller verification.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on every bus input.
- LONG_CYCLES, 82000: busy time for clear/home, in clk cycles.
- SHORT_CYCLES, 2000: busy time for every other instruction or data write.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- lcd_e  in  1  bus enable strobe
- lcd_rs  in  1  0=instruction, 1=data
- lcd_rw  in  1  0=write; 1 is unsupported
- lcd_db  in  8  data bus; only [7:4] are used, [3:0] ignored
- rd_addr  in  7  DDRAM readback address (HD44780 address space)
- rd_data  out  8  DDRAM byte at rd_addr, 1-cycle registered latency
- cmd_valid  out  1  1-cycle pulse per decoded instruction byte
- cmd_byte  out  8  instruction byte, valid with cmd_valid
- char_valid  out  1  1-cycle pulse per data byte written
- char_addr  out  7  DDRAM address written, valid with char_valid
- char_data  out  8  byte written, valid with char_valid
- addr_cnt  out  7  current address counter
- mode_4bit  out  1  interface is in 4-bit mode
- display_on  out  1  D bit of the last display-control instruction
- busy  out  1  instruction execution in progress
- err  out  3  sticky flags: [0] edge while busy, [1] rw=1 edge, [2] illegal DDRAM address

Behaviour:
- Input sampling
  - Each input passes through a SYNC_STAGES flop chain, then one more register (stage d).
  - A strobe is detected when e_d=1 and e_sync=0 (falling edge of E).
  - rs, rw and db[7:4] are taken from stage d on that cycle.
- Reset values
  - Interface in 8-bit mode, mode_4bit=0; nibble state MODE8.
  - addr_cnt=0, increment mode (I/D=1), display_on=0, busy=0, err=0.
  - All pulses 0; cmd_byte, char_addr, char_data and rd_data = 0.
  - DDRAM is NOT cleared by reset.
- Nibble state machine
  - MODE8: each strobe forms byte {db[7:4],4'b0000} and executes it. A function set with DL=0 sets mode_4bit=1 and moves to HI.
  - HI: latch the high nibble, go to LO.
  - LO: form {hi,db[7:4]}, execute it, return to HI.
  - A function set executed from the LO state with DL=1 returns the interface to MODE8.
- Strobes rejected without affecting nibble state
  - rw=1: ignored and sets err[1].
  - While busy=1: ignored and sets err[0].
- Execute
  - cmd_valid or char_valid pulses 1 cycle after the completing strobe.
  - busy rises that same cycle and stays high LONG_CYCLES or SHORT_CYCLES cycles.
- Instruction decode (rs=0)
  - 0x01 clear: write 0x20 to all 80 locations, one per cycle during busy; addr_cnt=0; I/D=1. Uses LONG_CYCLES.
  - 0x02–0x03 home: addr_cnt=0. Uses LONG_CYCLES.
  - 0x04–0x07 entry mode: I/D=bit1; the shift bit is ignored.
  - 0x08–0x0F: display_on=bit2.
  - 0x10–0x1F cursor/display shift and 0x40–0x7F CGRAM address: cmd_valid only, no other effect.
  - 0x20–0x3F function set: as described in the nibble state machine.
  - 0x80–0xFF: addr_cnt = byte[6:0]. If the address lies in 0x28–0x3F or 0x68–0x7F, set err[2] and load byte[6]<<6 instead.
- Data write (rs=1)
  - DDRAM[addr_cnt] <= byte.
  - char_addr = addr_cnt before the update.
  - addr_cnt then steps by +1 or -1 according to I/D.
- Address wrap
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
- DDRAM storage
  - 80×8 array, index = line*40 + col.
- Readback
  - rd_data returns the array content for legal addresses and 0x00 for illegal ones.
  - Data written on cycle N is visible at rd_data on cycle N+2.
- Reset mid-operation: aborts any clear fill and busy count; the partially filled DDRAM is retained.

Test Plan:
- Power-up sequence: nibbles 0x3,0x3,0x3,0x2 (busy respected) → mode_4bit=1 after the 4th; four cmd_valid pulses with cmd_byte 0x30,0x30,0x30,0x20.
- 4-bit config: pairs 0x28, 0x06, 0x0C, 0x01 → cmd_byte sequence matches; display_on=1; busy held 82000 cycles after 0x01; rd_data at 0x05 = 0x20.
- Set address and write: 0x80 then data 'H' (0x48), 'i' (0x69) → char_valid with char_addr 0x00 then 0x01; addr_cnt=0x02; rd_addr 0x01 → 0x69.
- Wrap: 0xA7 (address 0x27) then data 0x41 → char_addr=0x27, addr_cnt=0x40. Entry 0x04 then data at 0x40 → addr_cnt=0x27.
- Errors: a strobe 10 cycles after a data write → ignored, err[0]=1. rw=1 strobe → err[1]. 0xB0 → err[2]=1, addr_cnt=0x00.
- Reset during clear fill at cycle 30 → busy=0, addr_cnt=0, mode_4bit=0; locations already filled read 0x20, others keep their prior data.
